// File: rtl/mano_io_port_if.sv
// Device-side byte handshakes for mano_io_port.
// master = terminal device, slave = I/O port.
interface mano_io_port_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport master (
    output rx_valid,
    output rx_data,
    input  rx_ready,
    input  tx_valid,
    input  tx_data,
    output tx_ready
  );

  modport slave (
    input  rx_valid,
    input  rx_data,
    output rx_ready,
    output tx_valid,
    output tx_data,
    input  tx_ready
  );
endinterface

// File: rtl/mano_io_port.sv
// Mano basic computer terminal I/O: INPR/OUTR, FGI/FGO, IEN and IRQ.
// Define MANO_IO_RXFIFO_EN for an RX_DEPTH-entry receive FIFO.
module mano_io_port #(
  parameter int RX_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inp_rd,
  output logic [7:0] inpr,
  input  logic       out_wr,
  input  logic [7:0] out_data,
  output logic       fgi,
  output logic       fgo,
  input  logic       ion_set,
  input  logic       ion_clr,
  input  logic       int_ack,
  output logic       ien,
  output logic       irq,
  output logic       tx_err,
  mano_io_port_if.slave dev
);

  if (RX_DEPTH < 2 || (RX_DEPTH & (RX_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("RX_DEPTH must be a power of 2 and at least 2");
  end

`ifdef MANO_IO_RXFIFO_EN
  localparam int AW = $clog2(RX_DEPTH);

  logic [7:0]    mem [RX_DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          full;
  logic          push;
  logic          pop;

  assign full = (cnt == (AW+1)'(RX_DEPTH));
  assign push = dev.rx_valid & ~full;
  assign pop  = inp_rd & fgi;

  assign fgi          = (cnt != '0);
  assign dev.rx_ready = ~full;
  assign inpr         = fgi ? mem[rp] : 8'h00;

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= dev.rx_data;
  end

  // Pointers wrap for free since RX_DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
`else
  logic [7:0] inpr_q;
  logic       fgi_q;

  assign fgi          = fgi_q;
  assign inpr         = inpr_q;
  assign dev.rx_ready = ~fgi_q;

  // Load and clear are exclusive: loads need fgi=0, reads need fgi=1.
  always_ff @(posedge clk) begin
    if (rst) begin
      inpr_q <= 8'h00;
      fgi_q  <= 1'b0;
    end else if (dev.rx_valid & ~fgi_q) begin
      inpr_q <= dev.rx_data;
      fgi_q  <= 1'b1;
    end else if (inp_rd & fgi_q) begin
      fgi_q  <= 1'b0;
    end
  end
`endif

  logic [7:0] outr;
  logic       tx_valid_q;
  logic       tx_err_q;
  logic       ien_q;
  logic       irq_q;

  // FGO is simply "no byte pending for the output device".
  assign fgo          = ~tx_valid_q;
  assign dev.tx_valid = tx_valid_q;
  assign dev.tx_data  = outr;
  assign tx_err       = tx_err_q;
  assign ien          = ien_q;
  assign irq          = irq_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      outr       <= 8'h00;
      tx_valid_q <= 1'b0;
      tx_err_q   <= 1'b0;
    end else begin
      if (out_wr & ~tx_valid_q) begin
        outr       <= out_data;
        tx_valid_q <= 1'b1;
      end else if (tx_valid_q & dev.tx_ready) begin
        tx_valid_q <= 1'b0;
      end
      if (out_wr & tx_valid_q) tx_err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ien_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      irq_q <= ien_q & (fgi | fgo) & ~int_ack;
      if (ion_clr | int_ack) ien_q <= 1'b0;
      else if (ion_set)      ien_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mano_io_port.sv
// Randomised check of mano_io_port against a queue-based model.
// Build with +define+MANO_IO_RXFIFO_EN to cover the FIFO variant.
module tb_mano_io_port;
  localparam int RX_DEPTH = 4;
`ifdef MANO_IO_RXFIFO_EN
  localparam int MD = RX_DEPTH;
`else
  localparam int MD = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       inp_rd, out_wr, ion_set, ion_clr, int_ack;
  logic [7:0] out_data, inpr;
  logic       fgi, fgo, ien, irq, tx_err;

  mano_io_port_if dev ();

  mano_io_port #(.RX_DEPTH(RX_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .inp_rd(inp_rd), .inpr(inpr),
    .out_wr(out_wr), .out_data(out_data),
    .fgi(fgi), .fgo(fgo),
    .ion_set(ion_set), .ion_clr(ion_clr), .int_ack(int_ack),
    .ien(ien), .irq(irq), .tx_err(tx_err),
    .dev(dev.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] q[$];
  logic [7:0] m_last, m_outr;
  bit         m_txv, m_err, m_ien, m_irq;

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_inpr();
`ifdef MANO_IO_RXFIFO_EN
    return (q.size() != 0) ? q[0] : 8'h00;
`else
    return m_last;
`endif
  endfunction

  task automatic model_step();
    bit fg_i, fg_o, do_pop, do_push;
    fg_i = (q.size() != 0);
    fg_o = !m_txv;
    if (rst) begin
      q.delete();
      m_last = 0; m_outr = 0;
      m_txv = 0; m_err = 0; m_ien = 0; m_irq = 0;
      return;
    end
    m_irq = m_ien && (fg_i || fg_o) && !int_ack;
    if (ion_clr || int_ack) m_ien = 0;
    else if (ion_set)       m_ien = 1;
    do_push = dev.rx_valid && (q.size() < MD);
    do_pop  = inp_rd && fg_i;
    if (do_pop) void'(q.pop_front());
    if (do_push) begin
      q.push_back(dev.rx_data);
      m_last = dev.rx_data;
    end
    if (out_wr && !m_txv) begin
      m_outr = out_data;
      m_txv  = 1;
    end else begin
      if (out_wr) m_err = 1;
      if (m_txv && dev.tx_ready) m_txv = 0;
    end
  endtask

  task automatic check_all();
    chk("inpr", inpr, exp_inpr());
    chk("fgi", {7'd0, fgi}, {7'd0, q.size() != 0});
    chk("fgo", {7'd0, fgo}, {7'd0, !m_txv});
    chk("ien", {7'd0, ien}, {7'd0, m_ien});
    chk("irq", {7'd0, irq}, {7'd0, m_irq});
    chk("tx_err", {7'd0, tx_err}, {7'd0, m_err});
    chk("tx_valid", {7'd0, dev.tx_valid}, {7'd0, m_txv});
    chk("tx_data", dev.tx_data, m_outr);
    chk("rx_ready", {7'd0, dev.rx_ready}, {7'd0, q.size() < MD});
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    rst = 0; inp_rd = 0; out_wr = 0; out_data = 0;
    ion_set = 0; ion_clr = 0; int_ack = 0;
    dev.rx_valid = 0; dev.rx_data = 0; dev.tx_ready = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    cyc();
    rst = 0;
    chk("rst_fgo", {7'd0, fgo}, 8'd1);
    chk("rst_rx_ready", {7'd0, dev.rx_ready}, 8'd1);
    chk("rst_irq", {7'd0, irq}, 8'd0);

    dev.rx_valid = 1; dev.rx_data = 8'h41;
    cyc();
    dev.rx_valid = 0;
    chk("rx_inpr", inpr, 8'h41);
    chk("rx_fgi", {7'd0, fgi}, 8'd1);
    inp_rd = 1;
    cyc();
    inp_rd = 0;
    chk("rd_fgi", {7'd0, fgi}, 8'd0);
`ifndef MANO_IO_RXFIFO_EN
    chk("rd_inpr_kept", inpr, 8'h41);
`endif

    out_wr = 1; out_data = 8'h5A;
    cyc();
    out_wr = 0;
    chk("tx_load", dev.tx_data, 8'h5A);
    chk("tx_fgo", {7'd0, fgo}, 8'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("tx_stable", dev.tx_data, 8'h5A);
    end
    out_wr = 1; out_data = 8'h33;
    cyc();
    out_wr = 0;
    chk("tx_ignored", dev.tx_data, 8'h5A);
    chk("tx_err_set", {7'd0, tx_err}, 8'd1);
    dev.tx_ready = 1;
    cyc();
    dev.tx_ready = 0;
    chk("tx_done", {7'd0, dev.tx_valid}, 8'd0);

    ion_set = 1;
    cyc();
    ion_set = 0;
    cyc();
    chk("irq_on", {7'd0, irq}, 8'd1);
    int_ack = 1;
    cyc();
    int_ack = 0;
    chk("ack_irq", {7'd0, irq}, 8'd0);
    chk("ack_ien", {7'd0, ien}, 8'd0);
    ion_set = 1; ion_clr = 1;
    cyc();
    ion_set = 0; ion_clr = 0;
    chk("clr_wins", {7'd0, ien}, 8'd0);

`ifdef MANO_IO_RXFIFO_EN
    for (int i = 1; i <= 5; i++) begin
      dev.rx_valid = 1; dev.rx_data = 8'(i);
      cyc();
    end
    chk("ff_full", {7'd0, dev.rx_ready}, 8'd0);
    inp_rd = 1;
    cyc();
    inp_rd = 0;
    chk("ff_head", inpr, 8'h02);
    chk("ff_ready", {7'd0, dev.rx_ready}, 8'd1);
    cyc();
    dev.rx_valid = 0;
    for (int i = 2; i <= 5; i++) begin
      chk("ff_order", inpr, 8'(i));
      inp_rd = 1;
      cyc();
      inp_rd = 0;
    end
    chk("ff_empty", {7'd0, fgi}, 8'd0);
`endif

    out_wr = 1; out_data = 8'hC3;
    dev.rx_valid = 1; dev.rx_data = 8'h7E;
    cyc();
    idle();
    rst = 1;
    cyc();
    rst = 0;
    chk("rst_txv", {7'd0, dev.tx_valid}, 8'd0);
    chk("rst_fgi", {7'd0, fgi}, 8'd0);
    chk("rst_inpr", inpr, 8'h00);

    for (int n = 0; n < 3000; n++) begin
      rst          = ($urandom_range(0, 99) == 0);
      inp_rd       = ($urandom_range(0, 2) == 0);
      out_wr       = ($urandom_range(0, 3) == 0);
      out_data     = 8'($urandom);
      ion_set      = ($urandom_range(0, 5) == 0);
      ion_clr      = ($urandom_range(0, 15) == 0);
      int_ack      = ($urandom_range(0, 9) == 0);
      dev.rx_valid = ($urandom_range(0, 1) == 0);
      dev.rx_data  = 8'($urandom);
      dev.tx_ready = ($urandom_range(0, 2) == 0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
